// File: rtl/pc_sequencer.sv
// Fetch-stage next-PC generator with a circular return-address stack.
// Optional build macro PC_ALIGN_CHECK_EN aligns redirect targets and flags misalignment.
module pc_sequencer #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h3000),
    parameter int STEP = 4,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_enable,
    input  logic [1:0]       sel,
    input  logic             call,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] counter_value,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err,
    output logic             misalign
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_JMP = 2'b10;
    localparam logic [1:0] SEL_RET = 2'b11;

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [PW-1:0]    TOP_LAST = PW'(RAS_DEPTH - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] stack [RAS_DEPTH];
    logic [PW-1:0]    top;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] link;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] raw_pc;
    logic [WIDTH-1:0] next_pc;
    logic [PW-1:0]    top_up;
    logic [PW-1:0]    top_dn;
    logic [PW-1:0]    top_next;
    logic [CW-1:0]    count_next;
    logic             is_empty;
    logic             is_full;
    logic             is_ret;
    logic             do_pop;
    logic             do_push;
    logic             do_swap;
    logic             err_next;

    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_FULL);
    assign is_ret   = (sel == SEL_RET);

    assign ras_empty = is_empty;
    assign ras_full  = is_full;

    assign link    = counter_value + STEP_W;
    assign top_val = stack[top];

    assign top_up = (top == TOP_LAST) ? '0 : top + 1'b1;
    assign top_dn = (top == '0) ? TOP_LAST : top - 1'b1;

    // A return with a call on a non-empty stack replaces the top in place.
    assign do_pop  = is_ret && !is_empty && !call;
    assign do_swap = is_ret && !is_empty && call;
    assign do_push = call && !(is_ret && !is_empty);

    assign err_next = (is_ret && is_empty) || (do_push && is_full);

    always_comb begin
        raw_pc = link;
        unique case (sel)
            SEL_SEQ: raw_pc = link;
            SEL_BR:  raw_pc = counter_value + offset;
            SEL_JMP: raw_pc = target;
            SEL_RET: raw_pc = is_empty ? link : top_val;
        endcase
    end

    always_comb begin
        count_next = count;
        top_next   = top;
        if (do_pop) begin
            count_next = count - 1'b1;
            top_next   = top_dn;
        end else if (do_push) begin
            top_next = top_up;
            if (!is_full) begin
                count_next = count + 1'b1;
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] LOW_MASK = STEP_W - 1'b1;

    logic redirect;
    logic mis_next;

    assign redirect = (sel != SEL_SEQ);
    assign mis_next = redirect && (|(raw_pc & LOW_MASK));
    assign next_pc  = redirect ? (raw_pc & ~LOW_MASK) : raw_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= load_enable && mis_next;
        end
    end
`else
    assign next_pc  = raw_pc;
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter_value <= RESET_VECTOR - STEP_W;
            top           <= '0;
            count         <= '0;
            ras_err       <= 1'b0;
        end else if (load_enable) begin
            counter_value <= next_pc;
            top           <= top_next;
            count         <= count_next;
            ras_err       <= err_next;
        end else begin
            ras_err <= 1'b0;
        end
    end

    // Entry contents need no reset; only the count defines validity.
    always_ff @(posedge clk) begin
        if (load_enable) begin
            if (do_push) begin
                stack[top_up] <= link;
            end else if (do_swap) begin
                stack[top] <= link;
            end
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised next-generation program counter for the fetch stage. It generates the fetch address from five sources: sequential step, PC-relative branch, absolute jump, hold, and return from a built-in return-address stack (RAS) of configurable depth. A call flag pushes the link address onto the RAS. It directly replaces the fixed 32-bit PC-with-load register in the CPU top level.

Parameters:
WIDTH, 32, address width in bits
RESET_VECTOR, 32'h3000, first address fetched after reset
STEP, 4, sequential increment in bytes; must be a power of two
RAS_DEPTH, 4, number of return-stack entries; must be 2 or more

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
load_enable  in  1  1 = update PC this cycle; 0 = hold PC and RAS unchanged
sel  in  2  next-address source: 00 sequential, 01 branch relative, 10 jump absolute, 11 return (pop RAS)
call  in  1  when set with load_enable, push counter_value+STEP onto the RAS
offset  in  WIDTH  signed two's-complement branch displacement
target  in  WIDTH  absolute jump address
counter_value  out  WIDTH  current fetch address (registered)
ras_empty  out  1  RAS holds 0 entries (registered)
ras_full  out  1  RAS holds RAS_DEPTH entries (registered)
ras_err  out  1  one-cycle pulse on RAS overflow or underflow
misalign  out  1  one-cycle pulse on a misaligned redirect (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous):
  - counter_value = RESET_VECTOR - STEP, so the first enabled sequential update yields RESET_VECTOR.
  - RAS count = 0; ras_empty=1, ras_full=0, ras_err=0, misalign=0.
  - RAS entry contents are don't-care.
- All updates happen on the rising edge of clk while rst=1. Latency is 1 cycle: inputs sampled at edge N appear on counter_value after edge N.
- load_enable=0: PC, RAS, and count all hold; ras_err and misalign drive 0. The values of sel and call are ignored.
- load_enable=1, next PC by sel:
  - 00: counter_value + STEP
  - 01: counter_value + offset
  - 10: target
  - 11: top of RAS, popped; count decrements
- Arithmetic is modulo 2^WIDTH; wrap-around is silent.
- Link value for a push is always the pre-update counter_value + STEP.
- Push (call=1, sel≠11):
  - Not full: store at top, count+1.
  - Full: the stack is circular. The oldest entry is overwritten, count stays RAS_DEPTH, and ras_err pulses.
- Underflow (sel=11 with the RAS empty):
  - Next PC = counter_value + STEP.
  - Count stays 0; ras_err pulses.
- Simultaneous return and call (sel=11, call=1):
  - Next PC = old top of the RAS.
  - The top entry is replaced with the link value; count is unchanged (tail-call).
  - If the RAS is empty, the underflow rule applies to the PC, the link value is pushed (count becomes 1), and ras_err pulses.
- ras_empty and ras_full are derived from the registered count and are valid from the cycle after each update.
- Reset asserted mid-operation clears the RAS count immediately, regardless of clk.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - For sel 01, 10 and 11, the low log2(STEP) bits of the computed next PC are forced to 0 before loading.
  - misalign pulses for one cycle if any of those bits were nonzero.
  - The sequential path is never checked.
- Undefined:
  - The computed address is loaded unmodified.
  - misalign is tied to 0.
  - No check logic is synthesised.

Test Plan:
1. Reset/step: release rst, hold load_enable=1, sel=00 → counter_value reads 0x2FFC, then 0x3000, 0x3004, 0x3008; ras_empty=1.
2. Hold/branch/wrap:
   - With PC=0x3008, load_enable=0 for 3 cycles → PC stays 0x3008.
   - Then sel=01, offset=-8 → 0x3000.
   - From PC=0xFFFFFFFC, sel=00 → 0x00000000.
3. Call/return: at PC=0x3010, sel=10, call=1, target=0x4000 → PC=0x4000, RAS top=0x3014, ras_empty=0; then sel=11 → PC=0x3014, ras_empty=1.
4. Overflow/underflow (RAS_DEPTH=4):
   - 5 consecutive calls → ras_full=1 and ras_err pulses on the 5th call only.
   - 4 returns pop links 5, 4, 3, 2 in that order.
   - A 5th return at PC=P → PC=P+4, ras_err=1.
5. Tail-call: with RAS=[0x3014], sel=11, call=1 at PC=0x4008 → PC=0x3014, RAS=[0x400C], count stays 1.
6. With PC_ALIGN_CHECK_EN defined: sel=10, target=0x4002 → PC=0x4000, misalign=1 for one cycle. Without the macro, the same stimulus gives PC=0x4002, misalign=0.
